// File: rtl/y86_pkg.sv
// Shared Y86-64 constants used by the pipeline control unit and the
// pipeline registers it steers.
//
// Contents:
//   - icode encodings HALT (0x0) through POPQ (0xB)
//   - RNONE register id (0xF)
//   - status codes AOK/HLT/ADR/INS
//   - control FSM state type
//   - isExc(): true for statuses that must stop the pipeline
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] RNONE  = 4'hF;

    localparam logic [2:0] AOK    = 3'd1;
    localparam logic [2:0] HLT    = 3'd2;
    localparam logic [2:0] ADR    = 3'd3;
    localparam logic [2:0] INS    = 3'd4;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } ctrl_state_t;

    // A status that leaves the machine unable to continue: halt,
    // bad address or illegal instruction.
    function automatic logic isExc(input logic [2:0] stat);
        return (stat == ADR) || (stat == INS) || (stat == HLT);
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter used for the pipeline performance counters.
//
// Ports:
//   clk  - clock, counts on posedge
//   rst  - asynchronous active-high clear
//   inc  - count enable for this cycle
//   q    - current count; sticks at all-ones instead of wrapping
module sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Advance only when enabled and not already at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 5-stage Y86-64 pipeline.
//
// Looks at the D/E/M/W stage contents, detects load/use, ret and
// mispredict hazards plus exceptions, and drives the stall/bubble/set_cc
// controls of the pipeline registers. Once an exceptional status reaches
// W the unit freezes the machine in HALTED and records that status.
//
// Ports:
//   clk, rst                    - clock, async active-high reset
//   D_icode, E_icode, M_icode   - icodes held in the D/E/M registers
//   E_dstM                      - load destination of the E instruction
//   d_srcA, d_srcB              - source registers being decoded
//   e_Cnd                       - branch condition from execute
//   m_stat, W_stat              - memory-stage / W-register status
//   F_stall, D_stall, W_stall   - register hold controls
//   D_bubble, E_bubble, M_bubble- register NOP-insert controls
//   set_cc                      - condition-code write enable
//   cpu_stat, halted            - final status and halt flag
//   cyc_cnt, lu_cnt, mp_cnt, ret_cnt - saturating performance counters
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [2:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic [2:0]  cpuStat_q;
    logic [2:0]  cpuStat_d;

    logic luHaz;
    logic retHaz;
    logic mpHaz;
    logic mExc;
    logic wExc;
    logic running;

    // Hazard detection. Invalid icodes (>0xB) never equal any constant,
    // so they fall out as non-matching without extra logic.
    always_comb begin
        luHaz  = ((E_icode == MRMOVQ) || (E_icode == POPQ)) &&
                 (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        retHaz = (D_icode == RET) || (E_icode == RET) || (M_icode == RET);
        mpHaz  = (E_icode == JXX) && !e_Cnd;
        mExc   = isExc(m_stat);
        wExc   = isExc(W_stat);
    end

    // Counters and the halt transition only advance while the machine is
    // actually executing, never while reset is held.
    assign running = (state_q == S_RUN) && !rst;

    // Next state: an exception arriving in W halts the machine for good
    // and captures its status; only reset brings it back.
    always_comb begin
        state_d   = state_q;
        cpuStat_d = cpuStat_q;
        if ((state_q == S_RUN) && wExc) begin
            state_d   = S_HALTED;
            cpuStat_d = W_stat;
        end
    end

    // Control outputs. A load/use stall takes priority over the ret
    // bubble so D is never both stalled and bubbled.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else if (state_q == S_HALTED) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            F_stall  = luHaz | retHaz;
            D_stall  = luHaz;
            D_bubble = mpHaz | (retHaz & !luHaz);
            E_bubble = mpHaz | luHaz;
            M_bubble = mExc | wExc;
            W_stall  = wExc;
            set_cc   = (E_icode == OPQ) && !mExc && !wExc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RUN;
            cpuStat_q <= AOK;
        end else begin
            state_q   <= state_d;
            cpuStat_q <= cpuStat_d;
        end
    end

    assign cpu_stat = cpuStat_q;
    assign halted   = (state_q == S_HALTED);

    // A mispredict bubble outranks a ret bubble when both apply, so the
    // ret counter only sees cycles where ret alone caused the bubble.
    sat_cnt #(.CNT_W(CNT_W)) uCycCnt (
        .clk (clk),
        .rst (rst),
        .inc (running),
        .q   (cyc_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) uLuCnt (
        .clk (clk),
        .rst (rst),
        .inc (running && luHaz),
        .q   (lu_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) uMpCnt (
        .clk (clk),
        .rst (rst),
        .inc (running && mpHaz),
        .q   (mp_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) uRetCnt (
        .clk (clk),
        .rst (rst),
        .inc (running && retHaz && !luHaz && !mpHaz),
        .q   (ret_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. A 32-bit instance carries the main
// checks; a 4-bit instance on the same stimulus exercises saturation.
module tb_pipe_ctrl;
    import y86_pkg::*;

    logic clk;
    logic rst;
    logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
    logic       e_Cnd;
    logic [2:0] m_stat, W_stat;

    logic        mF, mD, mDb, mEb, mMb, mW, mCc, mHalted;
    logic [2:0]  mStat;
    logic [31:0] mCyc, mLu, mMp, mRet;

    logic        sF, sD, sDb, sEb, sMb, sW, sCc, sHalted;
    logic [2:0]  sStat;
    logic [3:0]  sCyc, sLu, sMp, sRet;

    int nCmp  = 0;
    int nFail = 0;

    typedef struct {
        string      tag;
        logic [6:0] ctrl;
    } exp_t;
    exp_t sbQ[$];

    int         expCyc, expLu, expMp, expRet;
    logic       expHalted;
    logic [2:0] expStat;

    // Control vector order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_CC    = 7'b0000001;
    localparam logic [6:0] C_LU    = 7'b1101000;
    localparam logic [6:0] C_MP    = 7'b0011000;
    localparam logic [6:0] C_RETB  = 7'b1010000;
    localparam logic [6:0] C_MPRET = 7'b1011000;
    localparam logic [6:0] C_MEXC  = 7'b0000100;
    localparam logic [6:0] C_WEXC  = 7'b0000110;
    localparam logic [6:0] C_HALT  = 7'b1101110;
    localparam logic [6:0] C_RST   = 7'b0011100;

    pipe_ctrl #(.CNT_W(32)) uMain (
        .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(mF), .D_stall(mD), .D_bubble(mDb), .E_bubble(mEb), .M_bubble(mMb),
        .W_stall(mW), .set_cc(mCc), .cpu_stat(mStat), .halted(mHalted),
        .cyc_cnt(mCyc), .lu_cnt(mLu), .mp_cnt(mMp), .ret_cnt(mRet)
    );

    pipe_ctrl #(.CNT_W(4)) uSat (
        .clk(clk), .rst(rst), .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(sF), .D_stall(sD), .D_bubble(sDb), .E_bubble(sEb), .M_bubble(sMb),
        .W_stall(sW), .set_cc(sCc), .cpu_stat(sStat), .halted(sHalted),
        .cyc_cnt(sCyc), .lu_cnt(sLu), .mp_cnt(sMp), .ret_cnt(sRet)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miss.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat4(input int v);
        return (v > 15) ? 64'd15 : 64'(v);
    endfunction

    // Pops the oldest expected control vector and compares both instances.
    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            check("sbEmpty", 64'd1, 64'd0);
        end else begin
            e = sbQ.pop_front();
            check({e.tag, ".ctrl"}, 64'({mF, mD, mDb, mEb, mMb, mW, mCc}), 64'(e.ctrl));
            check({e.tag, ".satCtrl"}, 64'({sF, sD, sDb, sEb, sMb, sW, sCc}), 64'(e.ctrl));
        end
    endtask

    task automatic checkState(input string tag);
        check({tag, ".cyc"},     64'(mCyc),    64'(expCyc));
        check({tag, ".lu"},      64'(mLu),     64'(expLu));
        check({tag, ".mp"},      64'(mMp),     64'(expMp));
        check({tag, ".ret"},     64'(mRet),    64'(expRet));
        check({tag, ".halted"},  64'(mHalted), 64'(expHalted));
        check({tag, ".stat"},    64'(mStat),   64'(expStat));
        check({tag, ".satCyc"},  64'(sCyc),    sat4(expCyc));
        check({tag, ".satLu"},   64'(sLu),     sat4(expLu));
        check({tag, ".satStat"}, 64'(sStat),   64'(expStat));
    endtask

    // Drives one cycle of stage contents, queues the expected controls,
    // checks them mid-cycle, then clocks and checks counters/state.
    task automatic applyStimulus(input string tag,
                                 input logic [3:0] dI, input logic [3:0] eI, input logic [3:0] mI,
                                 input logic [3:0] dstM, input logic [3:0] sA, input logic [3:0] sB,
                                 input logic cnd, input logic [2:0] ms, input logic [2:0] ws,
                                 input logic [6:0] ctrl, input int iLu, input int iMp, input int iRet);
        exp_t e;
        D_icode = dI; E_icode = eI; M_icode = mI;
        E_dstM = dstM; d_srcA = sA; d_srcB = sB;
        e_Cnd = cnd; m_stat = ms; W_stat = ws;
        e.tag = tag;
        e.ctrl = ctrl;
        sbQ.push_back(e);
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        if (!expHalted) begin
            expCyc++;
            expLu  += iLu;
            expMp  += iMp;
            expRet += iRet;
            if ((ws == ADR) || (ws == INS) || (ws == HLT)) begin
                expHalted = 1'b1;
                expStat   = ws;
            end
        end
        checkState(tag);
    endtask

    task automatic clearExp();
        expCyc = 0; expLu = 0; expMp = 0; expRet = 0;
        expHalted = 1'b0;
        expStat = AOK;
    endtask

    initial begin
        exp_t e;
        clearExp();
        rst = 1'b1;
        D_icode = NOP; E_icode = NOP; M_icode = NOP;
        E_dstM = RNONE; d_srcA = RNONE; d_srcB = RNONE;
        e_Cnd = 1'b0; m_stat = AOK; W_stat = AOK;

        #2;
        e.tag = "reset"; e.ctrl = C_RST; sbQ.push_back(e);
        checkOutput();
        @(posedge clk);
        #1;
        checkState("reset");
        #2;
        rst = 1'b0;

        //             tag        D      E       M     dstM  srcA  srcB  cnd  m_stat W_stat ctrl   lu mp ret
        applyStimulus("idle",    NOP,   NOP,    NOP,  RNONE,RNONE,RNONE,1'b0, AOK, AOK, C_NONE, 0, 0, 0);
        applyStimulus("opq",     NOP,   OPQ,    NOP,  RNONE,4'h1, 4'h2, 1'b0, AOK, AOK, C_CC,   0, 0, 0);
        applyStimulus("luA",     NOP,   MRMOVQ, NOP,  4'h3, 4'h3, 4'h5, 1'b0, AOK, AOK, C_LU,   1, 0, 0);
        applyStimulus("luB",     NOP,   POPQ,   NOP,  4'h4, 4'h1, 4'h4, 1'b0, AOK, AOK, C_LU,   1, 0, 0);
        applyStimulus("luRnone", NOP,   POPQ,   NOP,  RNONE,4'h1, RNONE,1'b0, AOK, AOK, C_NONE, 0, 0, 0);
        applyStimulus("mp",      NOP,   JXX,    NOP,  RNONE,RNONE,RNONE,1'b0, AOK, AOK, C_MP,   0, 1, 0);
        applyStimulus("taken",   NOP,   JXX,    NOP,  RNONE,RNONE,RNONE,1'b1, AOK, AOK, C_NONE, 0, 0, 0);
        applyStimulus("retD",    RET,   NOP,    NOP,  RNONE,RNONE,RNONE,1'b0, AOK, AOK, C_RETB, 0, 0, 1);
        applyStimulus("retE",    NOP,   RET,    NOP,  RNONE,RNONE,RNONE,1'b0, AOK, AOK, C_RETB, 0, 0, 1);
        applyStimulus("retM",    NOP,   NOP,    RET,  RNONE,RNONE,RNONE,1'b0, AOK, AOK, C_RETB, 0, 0, 1);
        applyStimulus("retDlu",  RET,   MRMOVQ, NOP,  4'h2, 4'h2, 4'h7, 1'b0, AOK, AOK, C_LU,   1, 0, 0);
        applyStimulus("retE2",   NOP,   RET,    NOP,  RNONE,RNONE,RNONE,1'b0, AOK, AOK, C_RETB, 0, 0, 1);
        applyStimulus("retM2",   NOP,   NOP,    RET,  RNONE,RNONE,RNONE,1'b0, AOK, AOK, C_RETB, 0, 0, 1);
        applyStimulus("mpRet",   RET,   JXX,    NOP,  RNONE,RNONE,RNONE,1'b0, AOK, AOK, C_MPRET,0, 1, 0);
        applyStimulus("badIcode",4'hC,  4'hE,   4'hF, 4'h3, 4'h3, 4'h3, 1'b0, AOK, AOK, C_NONE, 0, 0, 0);
        applyStimulus("mExc",    NOP,   OPQ,    NOP,  RNONE,RNONE,RNONE,1'b0, ADR, AOK, C_MEXC, 0, 0, 0);
        applyStimulus("wExc",    NOP,   OPQ,    NOP,  RNONE,RNONE,RNONE,1'b0, AOK, ADR, C_WEXC, 0, 0, 0);

        // Frozen machine: hazard-looking inputs must not move anything.
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("halt%0d", i), RET, MRMOVQ, RET, 4'h3, 4'h3, 4'h3,
                          1'b0, AOK, AOK, C_HALT, 0, 0, 0);
        end

        // Asynchronous reset in the middle of a halted cycle.
        #2;
        rst = 1'b1;
        #1;
        clearExp();
        e.tag = "asyncRst"; e.ctrl = C_RST; sbQ.push_back(e);
        checkOutput();
        checkState("asyncRst");
        #2;
        rst = 1'b0;

        applyStimulus("postRst", NOP,   NOP,    NOP,  RNONE,RNONE,RNONE,1'b0, AOK, AOK, C_NONE, 0, 0, 0);
        applyStimulus("wHlt",    NOP,   NOP,    NOP,  RNONE,RNONE,RNONE,1'b0, AOK, HLT, C_WEXC, 0, 0, 0);
        applyStimulus("halt2",   NOP,   OPQ,    NOP,  RNONE,RNONE,RNONE,1'b1, AOK, AOK, C_HALT, 0, 0, 0);

        check("sbDrained", 64'(sbQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
